// File: rtl/mem_responder.sv
// Wait-state memory responder in front of a 16-bit on-chip word array (SDRAM stand-in).
// Optional write protection below PROT_LIMIT: `define MEM_RESPONDER_PROTECT_EN.
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 2,
  parameter int PROT_LIMIT  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
  input  logic        read,
  input  logic        write,
  input  logic        instr_access,
  input  logic        read_done,
  output logic [15:0] rdata,
  output logic [31:0] instr_data,
  output logic        busy,
  output logic        cack,
  output logic        ready,
  output logic        prot_err
);

`ifdef MEM_RESPONDER_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif

  // Handshake: the core raises read/write (levels) only while busy is low; the request
  // is taken on the first edge it is seen in IDLE and cack pulses once to confirm it.
  // ready marks rdata/instr_data valid and stays high until read_done is seen at an edge.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_INSTR_HI = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [3:0]         cnt;
  logic [19:0]        addr_q;
  logic [15:0]        wdata_q;
  logic               is_write;
  logic               is_instr;
  logic [15:0]        mem [0:(1<<ADDR_W)-1];

  logic               req;
  logic               cnt_zero;
  logic               data_oor;
  logic               instr_oor;
  logic               wr_prot;
  logic               commit_slot;
  logic               mem_we;
  logic [ADDR_W-1:0]  data_idx;
  logic [ADDR_W-1:0]  instr_lo_idx;
  logic [ADDR_W-1:0]  instr_hi_idx;

  assign req          = read | write;
  assign cnt_zero     = (cnt == 4'd0);
  assign data_oor     = |addr_q[19:ADDR_W];
  assign instr_oor    = |addr_q[19:ADDR_W-1];
  assign data_idx     = addr_q[ADDR_W-1:0];
  assign instr_lo_idx = {addr_q[ADDR_W-2:0], 1'b0};
  assign instr_hi_idx = {addr_q[ADDR_W-2:0], 1'b1};
  assign wr_prot      = PROTECT_EN && ({12'd0, addr_q} < PROT_LIMIT);
  assign commit_slot  = (state == S_WAIT) && cnt_zero && is_write;
  // Out-of-range and protected writes still take their full slot, they just never land.
  assign mem_we       = commit_slot && !data_oor && !wr_prot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (req) state_nx = S_WAIT;
      S_WAIT: begin
        if (cnt_zero) begin
          if (is_write)      state_nx = S_IDLE;
          else if (is_instr) state_nx = S_INSTR_HI;
          else               state_nx = S_HOLD;
        end
      end
      S_INSTR_HI: state_nx = S_HOLD;
      S_HOLD:     if (read_done) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    ready = (state == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write   <= 1'b0;
      is_instr   <= 1'b0;
      cnt        <= '0;
      cack       <= 1'b0;
      prot_err   <= 1'b0;
      rdata      <= '0;
      instr_data <= '0;
    end else begin
      cack     <= 1'b0;
      prot_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            is_write <= write;
            is_instr <= instr_access & ~write;
            cnt      <= 4'(WAIT_STATES);
            cack     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!cnt_zero)
            cnt <= cnt - 4'd1;
          else if (!is_write && is_instr)
            instr_data[15:0] <= instr_oor ? 16'h0000 : mem[instr_lo_idx];
          else if (!is_write)
            rdata <= data_oor ? 16'h0000 : mem[data_idx];
          prot_err <= commit_slot && !data_oor && wr_prot;
        end
        S_INSTR_HI: instr_data[31:16] <= instr_oor ? 16'h0000 : mem[instr_hi_idx];
        default: ;
      endcase
    end
  end

  // The array has no reset: a mid-operation reset leaves its contents intact.
  always_ff @(posedge clk) begin
    if (mem_we) mem[data_idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) share stimulus and are
// checked cycle by cycle against a word-array reference model.
module tb_mem_responder;
  localparam int NDUT = 2;
  localparam int W_HI = 2;
  localparam int W_LO = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] addr;
  logic [15:0] wdata;
  logic        read, write, instr_access, read_done;
  logic [15:0] rdata_o [NDUT];
  logic [31:0] instr_o [NDUT];
  logic        busy_o  [NDUT];
  logic        cack_o  [NDUT];
  logic        ready_o [NDUT];
  logic        prot_o  [NDUT];

  int          w_of [NDUT] = '{W_HI, W_LO};
  int          total = 0;
  int          bad   = 0;
  logic [15:0] mem_model [4096];
  logic [15:0] exp_rdata;
  logic [31:0] exp_instr;
  logic [31:0] exp_q [$];

  mem_responder #(.ADDR_W(12), .WAIT_STATES(W_HI), .PROT_LIMIT(256)) u_dut_w2 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read(read), .write(write),
    .instr_access(instr_access), .read_done(read_done), .rdata(rdata_o[0]),
    .instr_data(instr_o[0]), .busy(busy_o[0]), .cack(cack_o[0]), .ready(ready_o[0]),
    .prot_err(prot_o[0])
  );

  mem_responder #(.ADDR_W(12), .WAIT_STATES(W_LO), .PROT_LIMIT(256)) u_dut_w0 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read(read), .write(write),
    .instr_access(instr_access), .read_done(read_done), .rdata(rdata_o[1]),
    .instr_data(instr_o[1]), .busy(busy_o[1]), .cack(cack_o[1]), .ready(ready_o[1]),
    .prot_err(prot_o[1])
  );

  always #5 clk = ~clk;

  // One request through both instances; n counts edges after the accepting edge E0.
  task automatic do_txn(input bit wr, input bit rd, input bit ins, input logic [19:0] a,
                        input logic [15:0] wd, input int extra, input bit early);
    bit          is_rd, is_ins, oor, prot;
    int          t_done [NDUT];
    int          r_edge, n_end, base;
    logic [31:0] res;
    is_rd  = rd && !wr;
    is_ins = is_rd && ins;
    prot   = 1'b0;
    res    = '0;
    if (wr) begin
      oor = (a >= 20'd4096);
`ifdef MEM_RESPONDER_PROTECT_EN
      prot = !oor && (a < 20'd256);
`endif
      if (!oor && !prot) mem_model[a[11:0]] = wd;
    end else if (is_ins) begin
      oor  = (a >= 20'd2048);
      base = int'(a[10:0]) * 2;
      res  = oor ? 32'h0 : {mem_model[base + 1], mem_model[base]};
      exp_instr = res;
      exp_q.push_back(res);
    end else begin
      oor = (a >= 20'd4096);
      res = {16'h0, oor ? 16'h0000 : mem_model[a[11:0]]};
      exp_rdata = res[15:0];
      exp_q.push_back(res);
    end
    for (int d = 0; d < NDUT; d++) t_done[d] = w_of[d] + (is_ins ? 2 : 1);
    r_edge = t_done[0] + 1 + extra;
    n_end  = is_rd ? r_edge : w_of[0] + 1;

    @(negedge clk);
    addr = a; wdata = wd; write = wr; read = rd; instr_access = ins;
    for (int n = 0; n <= n_end; n++) begin
      @(negedge clk);
      if (n == 0) begin write = 1'b0; read = 1'b0; instr_access = 1'b0; end
      for (int d = 0; d < NDUT; d++) begin
        bit e_busy, e_ready, e_prot, e_cack;
        e_cack  = (n == 0);
        e_busy  = is_rd ? (n < r_edge) : (n <= w_of[d]);
        e_ready = is_rd && (n >= t_done[d]) && (n < r_edge);
        e_prot  = prot && (n == w_of[d] + 1);
        total += 4;
        if (cack_o[d] !== e_cack) begin
          bad++; $display("FAIL cack dut%0d a=%h n=%0d got=%b exp=%b", d, a, n, cack_o[d], e_cack);
        end
        if (busy_o[d] !== e_busy) begin
          bad++; $display("FAIL busy dut%0d a=%h n=%0d got=%b exp=%b", d, a, n, busy_o[d], e_busy);
        end
        if (ready_o[d] !== e_ready) begin
          bad++; $display("FAIL ready dut%0d a=%h n=%0d got=%b exp=%b", d, a, n, ready_o[d], e_ready);
        end
        if (prot_o[d] !== e_prot) begin
          bad++; $display("FAIL prot_err dut%0d a=%h n=%0d got=%b exp=%b", d, a, n, prot_o[d], e_prot);
        end
        if (e_ready) begin
          total++;
          if (is_ins && instr_o[d] !== exp_q[0]) begin
            bad++; $display("FAIL instr_data dut%0d a=%h n=%0d got=%h exp=%h", d, a, n, instr_o[d], exp_q[0]);
          end else if (!is_ins && rdata_o[d] !== exp_q[0][15:0]) begin
            bad++; $display("FAIL rdata dut%0d a=%h n=%0d got=%h exp=%h", d, a, n, rdata_o[d], exp_q[0][15:0]);
          end
        end
      end
      read_done = (is_rd && (n + 1 == r_edge)) || (early && n == 0);
    end
    read_done = 1'b0;
    if (is_rd) void'(exp_q.pop_front());
    // Results must be untouched by anything but their own load cycles.
    for (int d = 0; d < NDUT; d++) begin
      total += 2;
      if (rdata_o[d] !== exp_rdata) begin
        bad++; $display("FAIL rdata_held dut%0d a=%h got=%h exp=%h", d, a, rdata_o[d], exp_rdata);
      end
      if (instr_o[d] !== exp_instr) begin
        bad++; $display("FAIL instr_held dut%0d a=%h got=%h exp=%h", d, a, instr_o[d], exp_instr);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      total += 6;
      if (busy_o[d] !== 1'b0)   begin bad++; $display("FAIL reset_busy dut%0d got=%b exp=0", d, busy_o[d]); end
      if (ready_o[d] !== 1'b0)  begin bad++; $display("FAIL reset_ready dut%0d got=%b exp=0", d, ready_o[d]); end
      if (cack_o[d] !== 1'b0)   begin bad++; $display("FAIL reset_cack dut%0d got=%b exp=0", d, cack_o[d]); end
      if (prot_o[d] !== 1'b0)   begin bad++; $display("FAIL reset_prot dut%0d got=%b exp=0", d, prot_o[d]); end
      if (rdata_o[d] !== 16'h0) begin bad++; $display("FAIL reset_rdata dut%0d got=%h exp=0", d, rdata_o[d]); end
      if (instr_o[d] !== 32'h0) begin bad++; $display("FAIL reset_instr dut%0d got=%h exp=0", d, instr_o[d]); end
    end
    rst = 1'b0;
    exp_rdata = '0;
    exp_instr = '0;
  endtask

  task automatic test_write_read;
    do_txn(1, 0, 0, 20'h00123, 16'hBEEF, 0, 0);
    do_txn(0, 1, 0, 20'h00123, 16'h0000, 0, 0);
    do_txn(0, 1, 0, 20'h00123, 16'h0000, 2, 1);
  endtask

  task automatic test_instr_fetch;
    do_txn(1, 0, 0, 20'h00040, 16'h1111, 0, 0);
    do_txn(1, 0, 0, 20'h00041, 16'h2222, 0, 0);
    do_txn(0, 1, 1, 20'h00020, 16'h0000, 0, 0);
    do_txn(1, 0, 0, 20'h00FFF, 16'hCAFE, 0, 0);
    do_txn(0, 1, 1, 20'h007FF, 16'h0000, 1, 0);
    do_txn(0, 1, 1, 20'h00800, 16'h0000, 0, 0);
  endtask

  task automatic test_out_of_range;
    do_txn(1, 0, 0, 20'h00000, 16'h0F0F, 0, 0);
    do_txn(0, 1, 0, 20'h10000, 16'h0000, 0, 0);
    do_txn(1, 0, 0, 20'h10000, 16'hDEAD, 0, 0);
    do_txn(0, 1, 0, 20'h00000, 16'h0000, 0, 0);
    do_txn(0, 1, 0, 20'h00800, 16'h0000, 0, 0);
  endtask

  task automatic test_rw_both;
    do_txn(1, 1, 0, 20'h00050, 16'h00AA, 0, 0);
    do_txn(0, 1, 0, 20'h00050, 16'h0000, 0, 0);
  endtask

  task automatic test_reset_mid;
    do_txn(1, 0, 0, 20'h00060, 16'h1234, 0, 0);
    @(negedge clk);
    addr = 20'h00060; wdata = 16'h5555; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    total += 2;
    if (busy_o[0] !== 1'b1) begin bad++; $display("FAIL mid_busy dut0 got=%b exp=1", busy_o[0]); end
    if (busy_o[1] !== 1'b1) begin bad++; $display("FAIL mid_busy dut1 got=%b exp=1", busy_o[1]); end
    rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      total += 4;
      if (busy_o[d] !== 1'b0)   begin bad++; $display("FAIL mid_rst_busy dut%0d got=%b exp=0", d, busy_o[d]); end
      if (cack_o[d] !== 1'b0)   begin bad++; $display("FAIL mid_rst_cack dut%0d got=%b exp=0", d, cack_o[d]); end
      if (rdata_o[d] !== 16'h0) begin bad++; $display("FAIL mid_rst_rdata dut%0d got=%h exp=0", d, rdata_o[d]); end
      if (instr_o[d] !== 32'h0) begin bad++; $display("FAIL mid_rst_instr dut%0d got=%h exp=0", d, instr_o[d]); end
    end
    exp_rdata = '0;
    exp_instr = '0;
    @(negedge clk);
    rst = 1'b0;
    do_txn(0, 1, 0, 20'h00060, 16'h0000, 0, 0);
  endtask

  task automatic test_protect;
    do_txn(1, 0, 0, 20'h00010, 16'h7777, 0, 0);
    do_txn(1, 0, 0, 20'h000FF, 16'h9999, 0, 0);
    do_txn(1, 0, 0, 20'h00100, 16'h8888, 0, 0);
    do_txn(0, 1, 0, 20'h00010, 16'h0000, 0, 0);
    do_txn(0, 1, 0, 20'h000FF, 16'h0000, 0, 0);
    do_txn(0, 1, 0, 20'h00100, 16'h0000, 0, 0);
  endtask

  task automatic test_random;
    logic [19:0] a;
    int          op;
    for (int i = 0; i < 64; i++) do_txn(1, 0, 0, 20'h00100 + 20'(i), 16'($urandom), 0, 0);
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      if (op == 2) a = ($urandom_range(0, 9) == 0) ? 20'h00800 | 20'($urandom_range(0, 1023))
                                                   : 20'h00080 + 20'($urandom_range(0, 31));
      else         a = ($urandom_range(0, 9) == 0) ? 20'h01000 | 20'($urandom)
                                                   : 20'h00100 + 20'($urandom_range(0, 63));
      do_txn(op == 0 || op == 3, op != 0, op == 2 || ($urandom_range(0, 1) == 1 && op == 3), a,
             16'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; read = 1'b0; write = 1'b0;
    instr_access = 1'b0; read_done = 1'b0;
    exp_rdata = '0; exp_instr = '0;
    test_reset();
    test_write_read();
    test_instr_fetch();
    test_out_of_range();
    test_rw_both();
    test_reset_mid();
    test_protect();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
